jt1943_prom_loader: RTL and testbench

- Writer side of the palette/selector PROM programming interface used by the colour mixer.
- Watches the ROM download byte stream and converts bytes in the PROM window into programming signals: prog_addr, prom_din and one-hot per-PROM write strobes.
- Tracks load progress and flags complete or short loads, so downstream video is released only once all PROMs are filled.

---
 rtl/jt1943_pkg.sv | 23 ++
 rtl/jt1943_prom_window.sv | 28 ++
 rtl/jt1943_prom_loader.sv | 135 +++++++++++++
 tb/tb_jt1943_prom_loader.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/jt1943_pkg.sv
// Shared constants and state encodings for the jt1943 PROM loaders.
// Imported by the window decoder and the loader top.
package jt1943_pkg;

  localparam int PROM_BYTES = 256;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam int P12A = 0;
  localparam int P13A = 1;
  localparam int P14A = 2;
  localparam int P12C = 3;

  // Total PROM bytes expected for a given PROM count.
  function automatic int prom_total(input int count);
    return count * PROM_BYTES;
  endfunction

endpackage

// File: rtl/jt1943_prom_window.sv
// Combinational PROM window decode for a download byte address.
// Gives hit flag, PROM index and address within that PROM.
module jt1943_prom_window
  import jt1943_pkg::*;
#(
  parameter int             AW    = 22,
  parameter logic [AW-1:0]  START = 'h1_0000,
  parameter int             COUNT = 4
) (
  input  logic [AW-1:0] i_addr,
  output logic          o_hit,
  output logic [2:0]    o_idx,
  output logic [7:0]    o_addr
);

  localparam logic [AW:0] LIMIT = (AW+1)'(prom_total(COUNT));

  logic [AW-1:0] w_off;

  // Offset from window base; index and address fall out of its low bits.
  always_comb begin
    w_off  = i_addr - START;
    o_hit  = (i_addr >= START) && ({1'b0, w_off} < LIMIT);
    o_idx  = w_off[10:8];
    o_addr = w_off[7:0];
  end

endmodule

// File: rtl/jt1943_prom_loader.sv
// PROM loader: turns download bytes into PROM write strobes.
// Optional prom_sum nibble checksum with JT1943_PROM_CHECKSUM_EN.
module jt1943_prom_loader
  import jt1943_pkg::*;
#(
  parameter int            AW         = 22,
  parameter logic [AW-1:0] PROM_START = 'h1_0000,
  parameter int            PROM_COUNT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  downloading,
  input  logic [AW-1:0]         ioctl_addr,
  input  logic [7:0]            ioctl_data,
  input  logic                  ioctl_wr,
  output logic [7:0]            prog_addr,
  output logic [3:0]            prom_din,
  output logic [PROM_COUNT-1:0] prom_we,
`ifdef JT1943_PROM_CHECKSUM_EN
  output logic [7:0]            prom_sum,
`endif
  output logic                  done,
  output logic                  short_load
);

  localparam int TOT = prom_total(PROM_COUNT);
  localparam int CW  = $clog2(TOT + 1);
  localparam logic [CW-1:0] TOTAL = CW'(TOT);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [7:0]      r_addr;
  logic [3:0]      r_din;
  logic [PROM_COUNT-1:0] r_we;
  logic            r_done;
  logic            r_short;

  logic            w_hit;
  logic [2:0]      w_idx;
  logic [7:0]      w_paddr;
  logic            w_accept;
  logic [CW-1:0]   w_cnt_nxt;
  logic [3:0]      w_nib;

  jt1943_prom_window #(
    .AW    (AW),
    .START (PROM_START),
    .COUNT (PROM_COUNT)
  ) u_win (
    .i_addr (ioctl_addr),
    .o_hit  (w_hit),
    .o_idx  (w_idx),
    .o_addr (w_paddr)
  );

  // Accept in-window bytes in LOAD, including the falling-edge cycle.
  always_comb begin
    w_nib     = 4'(ioctl_data);
    w_accept  = ioctl_wr && w_hit && (r_state == ST_LOAD);
    w_cnt_nxt = r_cnt;
    if (w_accept && (r_cnt != TOTAL))
      w_cnt_nxt = r_cnt + 1'b1;
  end

  // Write path: one-cycle strobe, address and data held until next byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_din  <= '0;
      r_we   <= '0;
    end else begin
      r_we <= '0;
      if (w_accept) begin
        r_addr <= w_paddr;
        r_din  <= w_nib;
        r_we   <= PROM_COUNT'(1) << w_idx;
      end
    end
  end

  // Load FSM, byte counter and completion flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_short <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_cnt <= w_cnt_nxt;
          if (!downloading) begin
            r_state <= ST_DONE;
            r_done  <= (w_cnt_nxt == TOTAL);
            r_short <= (w_cnt_nxt != TOTAL);
          end
        end
        ST_IDLE, ST_DONE: begin
          if (downloading) begin
            r_state <= ST_LOAD;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_short <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef JT1943_PROM_CHECKSUM_EN
  logic [7:0] r_sum;

  // Nibble checksum, restarted whenever a new load begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (r_state != ST_LOAD) begin
      if (downloading)
        r_sum <= '0;
    end else if (w_accept) begin
      r_sum <= r_sum + {4'h0, w_nib};
    end
  end

  assign prom_sum = r_sum;
`endif

  assign prog_addr  = r_addr;
  assign prom_din   = r_din;
  assign prom_we    = r_we;
  assign done       = r_done;
  assign short_load = r_short;

endmodule

// File: tb/tb_jt1943_prom_loader.sv
// Randomized bench for jt1943_prom_loader against a behavioural model.
// Define JT1943_PROM_CHECKSUM_EN to also check prom_sum.
module tb_jt1943_prom_loader;

  localparam int START = 32'h1_0000;
  localparam int NB    = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        downloading = 1'b0;
  logic [21:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  prog_addr;
  logic [3:0]  prom_din;
  logic [3:0]  prom_we;
  logic        done;
  logic        short_load;
`ifdef JT1943_PROM_CHECKSUM_EN
  logic [7:0]  prom_sum;
`endif

  jt1943_prom_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_data  (ioctl_data),
    .ioctl_wr    (ioctl_wr),
    .prog_addr   (prog_addr),
    .prom_din    (prom_din),
    .prom_we     (prom_we),
`ifdef JT1943_PROM_CHECKSUM_EN
    .prom_sum    (prom_sum),
`endif
    .done        (done),
    .short_load  (short_load)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  bit m_load;
  int m_cnt, m_sum;
  bit m_done, m_short;
  int e_we, e_addr, e_din;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_load = 0; m_cnt = 0; m_sum = 0;
    m_done = 0; m_short = 0;
    e_we = 0; e_addr = 0; e_din = 0;
  endtask

  // One clock: drive, advance past the edge, update model, compare.
  task automatic step(input bit dl, input int a, input int d, input bit wr);
    int off;
    bit win;
    downloading = dl;
    ioctl_addr  = 22'(a);
    ioctl_data  = 8'(d);
    ioctl_wr    = wr;
    @(posedge clk);
    #1;
    a   = a & 32'h3F_FFFF;
    off = a - START;
    win = (a >= START) && (off < NB);
    e_we = 0;
    if (!m_load) begin
      if (dl) begin
        m_load = 1; m_cnt = 0; m_sum = 0;
        m_done = 0; m_short = 0;
      end
    end else begin
      if (wr && win) begin
        e_we   = 1 << (off / 256);
        e_addr = off % 256;
        e_din  = (d & 255) % 16;
        if (m_cnt < NB) m_cnt = m_cnt + 1;
        m_sum = (m_sum + e_din) % 256;
      end
      if (!dl) begin
        m_load  = 0;
        m_done  = (m_cnt == NB);
        m_short = !m_done;
      end
    end
    chk("we", prom_we, e_we);
    chk("done", done, m_done);
    chk("short", short_load, m_short);
    if (e_we != 0) begin
      chk("addr", prog_addr, e_addr);
      chk("din", prom_din, e_din);
    end
`ifdef JT1943_PROM_CHECKSUM_EN
    chk("sum", prom_sum, m_sum);
`endif
  endtask

  // Load n sequential bytes; dmode<0 means data = addr nibble + junk.
  task automatic load(input int n, input int gmax, input int dmode,
                      input bit fall_last, input int b2b_tail);
    int d;
    bit last;
    step(1, $urandom, $urandom, 0);
    for (int i = 0; i < n; i++) begin
      if (i < n - b2b_tail)
        repeat ($urandom_range(gmax, 0))
          step(1, $urandom, $urandom, 0);
      d = (dmode < 0) ? (($urandom & 8'hF0) | (i & 15)) : dmode;
      last = fall_last && (i == n - 1);
      step(!last, START + i, d, 1);
      if (i == 12'h1FF && dmode < 0) begin
        chk("b1ff_we", prom_we, 4'b0010);
        chk("b1ff_addr", prog_addr, 8'hFF);
        chk("b1ff_din", prom_din, 4'hF);
      end
    end
    if (!fall_last) step(0, $urandom, $urandom, 0);
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_we", prom_we, 0);
    chk("rst_addr", prog_addr, 0);
    chk("rst_din", prom_din, 0);
    chk("rst_done", done, 0);
    chk("rst_short", short_load, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // Writes while idle are ignored
    repeat (3) step(0, START + $urandom_range(1023, 0), $urandom, 1);

    // Full load with random gaps
    load(NB, 2, -1, 0, 0);
    chk("full_done", done, 1);
    chk("full_short", short_load, 0);
    // Writes in DONE with downloading low are ignored
    repeat (3) step(0, START + $urandom_range(1023, 0), $urandom, 1);

    // Out-of-window writes do not count: 1023 bytes plus OOW is short
    step(1, 0, 0, 0);
    for (int i = 0; i < NB - 1; i++) begin
      if (i % 100 == 7) step(1, START - 1, $urandom, 1);
      if (i % 100 == 50) step(1, START + NB, $urandom, 1);
      step(1, START + i, $urandom, 1);
    end
    step(1, START - 1, $urandom, 1);
    step(1, START + NB, $urandom, 1);
    step(0, 0, 0, 0);
    chk("oow_short", short_load, 1);
    chk("oow_done", done, 0);

    // Short load of 1000 bytes
    load(1000, 1, -1, 0, 0);
    chk("short_flag", short_load, 1);
    chk("short_done", done, 0);

    // Back-to-back tail, last byte coincident with falling edge
    load(NB, 1, -1, 1, 4);
    chk("edge_we", prom_we, 4'b1000);
    chk("edge_addr", prog_addr, 8'hFF);
    chk("edge_done", done, 1);
    chk("edge_short", short_load, 0);
    step(0, 0, 0, 0);

    // Reset mid-load
    step(1, 0, 0, 0);
    for (int i = 0; i < 500; i++) step(1, START + i, $urandom, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_we", prom_we, 0);
    chk("arst_addr", prog_addr, 0);
    chk("arst_din", prom_din, 0);
    chk("arst_done", done, 0);
    chk("arst_short", short_load, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    downloading = 1'b0;
    step(0, 0, 0, 0);
    load(NB, 1, -1, 0, 0);
    chk("reload_done", done, 1);

`ifdef JT1943_PROM_CHECKSUM_EN
    load(NB, 1, 8'h0F, 0, 0);
    chk("sum_0f", prom_sum, 8'h00);
    load(NB, 0, 8'h01, 0, 0);
    chk("sum_01", prom_sum, 8'h00);
    load(3, 1, 8'h05, 0, 0);
    chk("sum_05", prom_sum, 8'h0F);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
